// File: rtl/checker_hm_pkg.sv
// Shared types and constants for the host-memory qword reader.
package checker_hm_pkg;

    localparam int unsigned ADDR_W      = 64;
    localparam int unsigned OFFSET_W    = 12;
    localparam int unsigned COUNT_W     = 10;
    localparam int unsigned DATA_W      = 64;
    localparam int unsigned PAGE_SIZE   = 4096;
    localparam int unsigned QWORD_BYTES = 8;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        PUSH,
        DONE
    } state_t;

endpackage

// File: rtl/checker_hm_reader.sv
// Reads a run of qwords from host memory one request at a time, with a local
// watchdog, bounded retries and a valid/ready output stream.
module checker_hm_reader
    import checker_hm_pkg::*;
#(
    parameter int unsigned MAX_RETRY = 3,
    parameter int unsigned WD_CYCLES = 255
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    input  logic                en,
    input  logic                cmd_start,
    input  logic [ADDR_W-1:0]   cmd_page_addr,
    input  logic [OFFSET_W-1:0] cmd_page_offset,
    input  logic [COUNT_W-1:0]  cmd_count,
    output logic                cmd_busy,
    output logic                cmd_done,
    output logic                cmd_error,
    output logic                out_valid,
    output logic [DATA_W-1:0]   out_data,
    input  logic                out_ready,
    output logic                hm_start,
    output logic [ADDR_W-1:0]   hm_page_addr,
    output logic [OFFSET_W-1:0] hm_page_offset,
    input  logic                hm_end,
    input  logic [DATA_W-1:0]   hm_data,
    input  logic                hm_timeout
);

    localparam int unsigned RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int unsigned WD_W    = (WD_CYCLES > 1) ? $clog2(WD_CYCLES) : 1;

    localparam logic [RETRY_W-1:0]  RETRY_LAST = RETRY_W'(MAX_RETRY);
    localparam logic [WD_W-1:0]     WD_LAST    = WD_W'(WD_CYCLES - 1);
    localparam logic [OFFSET_W-1:0] QW_MASK    = ~OFFSET_W'(QWORD_BYTES - 1);
    localparam logic [OFFSET_W-1:0] OFF_LAST   = OFFSET_W'(PAGE_SIZE - QWORD_BYTES);
    localparam logic [OFFSET_W-1:0] OFF_STEP   = OFFSET_W'(QWORD_BYTES);
    localparam logic [ADDR_W-1:0]   PAGE_STEP  = ADDR_W'(PAGE_SIZE);

    state_t               state_q, state_d;
    logic [WD_W-1:0]      wd_q, wd_d;
    logic [RETRY_W-1:0]   retry_q, retry_d;
    logic [COUNT_W-1:0]   count_q, count_d;
    logic                 hm_start_d;
    logic [ADDR_W-1:0]    addr_d;
    logic [OFFSET_W-1:0]  off_d;
    logic                 out_valid_d;
    logic [DATA_W-1:0]    out_data_d;
    logic                 cmd_busy_d;
    logic                 cmd_done_d;
    logic                 cmd_error_d;

    // State and output registers; en low freezes every one of them.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q        <= IDLE;
            wd_q           <= '0;
            retry_q        <= '0;
            count_q        <= '0;
            hm_start       <= 1'b0;
            hm_page_addr   <= '0;
            hm_page_offset <= '0;
            out_valid      <= 1'b0;
            out_data       <= '0;
            cmd_busy       <= 1'b0;
            cmd_done       <= 1'b0;
            cmd_error      <= 1'b0;
        end else if (en) begin
            state_q        <= state_d;
            wd_q           <= wd_d;
            retry_q        <= retry_d;
            count_q        <= count_d;
            hm_start       <= hm_start_d;
            hm_page_addr   <= addr_d;
            hm_page_offset <= off_d;
            out_valid      <= out_valid_d;
            out_data       <= out_data_d;
            cmd_busy       <= cmd_busy_d;
            cmd_done       <= cmd_done_d;
            cmd_error      <= cmd_error_d;
        end
    end

    // Next state; hm_start and cmd_done are set on the transition into
    // REQ/DONE so each is high exactly while the FSM sits in that state.
    always_comb begin
        state_d     = state_q;
        wd_d        = wd_q;
        retry_d     = retry_q;
        count_d     = count_q;
        hm_start_d  = 1'b0;
        addr_d      = hm_page_addr;
        off_d       = hm_page_offset;
        out_valid_d = out_valid;
        out_data_d  = out_data;
        cmd_busy_d  = cmd_busy;
        cmd_done_d  = 1'b0;
        cmd_error_d = cmd_error;

        case (state_q)
            IDLE: begin
                if (cmd_start) begin
                    addr_d      = cmd_page_addr;
                    off_d       = cmd_page_offset & QW_MASK;
                    count_d     = cmd_count;
                    cmd_busy_d  = 1'b1;
                    cmd_error_d = 1'b0;
                    wd_d        = '0;
                    retry_d     = '0;
                    if (cmd_count == '0) begin
                        state_d    = DONE;
                        cmd_done_d = 1'b1;
                    end else begin
                        state_d    = REQ;
                        hm_start_d = 1'b1;
                    end
                end
            end

            REQ: begin
                state_d = WAIT;
            end

            WAIT: begin
                if (hm_end) begin
                    out_data_d  = hm_data;
                    out_valid_d = 1'b1;
                    state_d     = PUSH;
                end else if (hm_timeout || (wd_q == WD_LAST)) begin
                    if (retry_q == RETRY_LAST) begin
                        state_d     = DONE;
                        cmd_done_d  = 1'b1;
                        cmd_error_d = 1'b1;
                    end else begin
                        retry_d    = retry_q + RETRY_W'(1);
                        wd_d       = '0;
                        state_d    = REQ;
                        hm_start_d = 1'b1;
                    end
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end

            PUSH: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    count_d     = count_q - COUNT_W'(1);
                    off_d       = hm_page_offset + OFF_STEP;
                    if (hm_page_offset == OFF_LAST) begin
                        addr_d = hm_page_addr + PAGE_STEP;
                    end
                    if (count_q == COUNT_W'(1)) begin
                        state_d    = DONE;
                        cmd_done_d = 1'b1;
                    end else begin
                        wd_d       = '0;
                        retry_d    = '0;
                        state_d    = REQ;
                        hm_start_d = 1'b1;
                    end
                end
            end

            DONE: begin
                cmd_busy_d = 1'b0;
                state_d    = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: doc/checker_hm_reader.md
CHECKER_HM_READER -- requirements
Module: checker_hm_reader

Interface
REQ-001 SHALL have parameter MAX_RETRY, default 3, meaning the number of re-issues of one qword request after a timeout.
REQ-002 SHALL have parameter WD_CYCLES, default 255, meaning the number of cycles the local watchdog waits for a response.
REQ-003 SHALL have port sys_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port sys_rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port en, input, 1 bit: global enable; when low, all state is frozen and all outputs hold.
REQ-006 SHALL have port cmd_start, input, 1 bit: one-cycle command pulse.
REQ-007 SHALL have port cmd_page_addr, input, 64 bits: start page base address.
REQ-008 SHALL have port cmd_page_offset, input, 12 bits: start byte offset; bits [2:0] ignored.
REQ-009 SHALL have port cmd_count, input, 10 bits: number of qwords; 0 means none.
REQ-010 SHALL have output ports cmd_busy (1), cmd_done (1, pulse) and cmd_error (1, valid with cmd_done).
REQ-011 SHALL have output ports out_valid (1) and out_data (64), plus input port out_ready (1): the qword stream.
REQ-012 SHALL have output ports hm_start (1), hm_page_addr (64) and hm_page_offset (12): host-memory request.
REQ-013 SHALL have input ports hm_end (1), hm_data (64) and hm_timeout (1): host-memory response.

Function
REQ-014 SHALL implement states IDLE, REQ, WAIT, PUSH and DONE.
REQ-015 In IDLE, cmd_start SHALL latch the address, offset (bits [2:0] cleared) and count, and set cmd_busy; the next state is REQ, or DONE if count is 0.
REQ-016 REQ SHALL drive hm_start high for exactly one enabled cycle, with hm_page_addr/hm_page_offset stable from REQ until the response is accepted, then go to WAIT.
REQ-017 In WAIT, hm_end SHALL capture hm_data into out_data, set out_valid and go to PUSH.
REQ-018 In WAIT, hm_timeout, or the watchdog reaching WD_CYCLES cycles, SHALL increment the retry counter and go back to REQ.
REQ-019 A retry when the retry counter already equals MAX_RETRY SHALL instead go to DONE with cmd_error set.
REQ-020 hm_end and hm_timeout in the same cycle SHALL be treated as hm_end.
REQ-021 The watchdog and retry counter SHALL clear on every entry to REQ from PUSH or IDLE; only the watchdog clears on a retry.
REQ-022 PUSH SHALL hold out_valid and out_data until out_ready is high, then clear out_valid, decrement the count and advance the offset by 8.
REQ-023 An offset wrap from 0xFF8 to 0x000 SHALL add 0x1000 to the page address (64-bit wrap).
REQ-024 After the final qword, PUSH SHALL go to DONE; otherwise it SHALL go to REQ.
REQ-025 DONE SHALL pulse cmd_done for one cycle, clear cmd_busy and return to IDLE; cmd_error SHALL hold until the next cmd_start.
REQ-026 cmd_start outside IDLE SHALL be ignored.
REQ-027 hm_end and hm_timeout outside WAIT SHALL be ignored.
REQ-028 out_valid SHALL never deassert without out_ready.
REQ-029 Latency SHALL be 1 cycle from hm_end to out_valid, and 1 cycle from acceptance to the next hm_start.

Reset
REQ-030 Asserting sys_rst_n low SHALL immediately force state IDLE and set all outputs to 0: hm_start, hm_page_addr, hm_page_offset, out_valid, out_data, cmd_busy, cmd_done, cmd_error.
REQ-031 Reset mid-transfer SHALL abandon the command; any later response SHALL be ignored per REQ-027.

Structure
REQ-032 A shared package checker_hm_pkg SHALL hold the state enum, PAGE_SIZE (4096), QWORD_BYTES (8) and the width constants (64/12/10).
REQ-033 The block SHALL be a single module with no sub-module.

Verification
REQ-034 Scenario: addr 0x2000, offset 0x010, count 3; responder returns hm_end after 2 cycles; out_ready always 1 -> 3 hm_start pulses at offsets 0x010/0x018/0x020, 3 out_valid beats, cmd_done with cmd_error 0.
REQ-035 Scenario: offset 0xFF8, count 2 -> second request uses addr 0x3000, offset 0x000.
REQ-036 Scenario: responder always asserts hm_timeout 9 cycles after hm_start -> 4 hm_start pulses, then cmd_done with cmd_error 1 and no out_valid.
REQ-037 Scenario: responder silent -> watchdog retries every 255 cycles and errors after 4 attempts; then, with hm_end and hm_timeout asserted together, the data is taken.
REQ-038 Scenario: out_ready low for 5 cycles -> out_valid/out_data stable, no new hm_start; en low for 4 cycles mid-WAIT freezes everything.
REQ-039 Scenario: sys_rst_n pulsed low in WAIT -> outputs 0 immediately; a later hm_end is ignored; a new command of count 1 then completes normally.
